// File: rtl/ps2_led_sequencer_pkg.sv
// ps2_led_sequencer_pkg: shared state encoding, PS/2 command bytes and lock-key codes
package ps2_led_sequencer_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_CMD  = 3'd1;
    localparam logic [2:0] ST_WAIT_TX1  = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK1 = 3'd3;
    localparam logic [2:0] ST_SEND_ARG  = 3'd4;
    localparam logic [2:0] ST_WAIT_TX2  = 3'd5;
    localparam logic [2:0] ST_WAIT_ACK2 = 3'd6;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;

    localparam logic [7:0] KEY_CAPS     = 8'h58;
    localparam logic [7:0] KEY_NUM      = 8'h77;
    localparam logic [7:0] KEY_SCROLL   = 8'h7E;

    function automatic logic [2:0] lock_hit(input logic [7:0] code);
        return {code == KEY_CAPS, code == KEY_NUM, code == KEY_SCROLL};
    endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// ps2_timeout_counter: counts enabled cycles, expired marks the LIMIT-th enabled cycle
module ps2_timeout_counter #(
    parameter int LIMIT = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // clear wins over enable so the count restarts on entry to the wait state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    assign expired = enable && count == LAST;

endmodule

// File: rtl/ps2_led_sequencer.sv
// ps2_led_sequencer: tracks lock keys and sends the 0xED LED command with retry/timeout
module ps2_led_sequencer #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_data_stb,
    input  logic [7:0] key_data,
    input  logic       key_broken,
    input  logic       rx_done_stb,
    input  logic [7:0] rx_data,
    output logic       rx_enable,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done_stb,
    input  logic       tx_err,
    output logic       rx_fwd_stb,
    output logic [7:0] rx_fwd_data,
    output logic [2:0] lock_state,
    output logic       err_stb
);

    import ps2_led_sequencer_pkg::*;

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    logic [2:0]    state;
    logic [2:0]    arg;
    logic          pending;
    logic [RW-1:0] retries;
    logic [2:0]    hit;
    logic [2:0]    resend_state;
    logic          in_tx, in_ack, tx_ok, rsp_ack, rsp_resend, retry, expired, give_up, launch;

    assign hit          = (key_data_stb && !key_broken) ? lock_hit(key_data) : 3'b000;
    assign in_tx        = state == ST_WAIT_TX1 || state == ST_WAIT_TX2;
    assign in_ack       = state == ST_WAIT_ACK1 || state == ST_WAIT_ACK2;
    assign tx_ok        = in_tx && tx_done_stb && !tx_err;
    assign rsp_ack      = in_ack && rx_done_stb && rx_data == RSP_ACK;
    assign rsp_resend   = in_ack && rx_done_stb && rx_data == RSP_RESEND;
    assign retry        = (in_tx && tx_done_stb && tx_err) || rsp_resend;
    assign give_up      = (retry && retries == RETRY_LAST) || (in_ack && expired && !rsp_ack && !rsp_resend);
    assign launch       = state == ST_IDLE && pending;
    assign resend_state = (state == ST_WAIT_TX1 || state == ST_WAIT_ACK1) ? ST_SEND_CMD : ST_SEND_ARG;

    ps2_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tx_ok),
        .enable  (in_ack),
        .expired (expired)
    );

    // lock toggles; a new toggle outranks a launch so the fresh state is always sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= 3'b000;
            pending    <= 1'b0;
        end else begin
            lock_state <= lock_state ^ hit;
            if (|hit)
                pending <= 1'b1;
            else if (launch)
                pending <= 1'b0;
        end
    end

    // command sequencer: 0xED then the LED argument, each acknowledged with retry and timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            arg       <= 3'b000;
            retries   <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            rx_enable <= 1'b1;
            err_stb   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            err_stb  <= 1'b0;
            case (state)
                ST_IDLE: if (pending) begin
                    state   <= ST_SEND_CMD;
                    arg     <= lock_state;
                    retries <= '0;
                end
                ST_SEND_CMD, ST_SEND_ARG: begin
                    tx_start  <= 1'b1;
                    tx_data   <= state == ST_SEND_CMD ? CMD_SET_LEDS : {5'b00000, arg};
                    rx_enable <= 1'b0;
                    state     <= state == ST_SEND_CMD ? ST_WAIT_TX1 : ST_WAIT_TX2;
                end
                ST_WAIT_TX1, ST_WAIT_TX2: if (tx_done_stb) begin
                    rx_enable <= 1'b1;
                    err_stb   <= give_up;
                    state     <= give_up ? ST_IDLE : tx_err ? resend_state :
                                 state == ST_WAIT_TX1 ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
                    if (tx_err)
                        retries <= retries + 1'b1;
                end
                ST_WAIT_ACK1, ST_WAIT_ACK2: if (give_up) begin
                    state   <= ST_IDLE;
                    err_stb <= 1'b1;
                end else if (rsp_resend) begin
                    state   <= resend_state;
                    retries <= retries + 1'b1;
                end else if (rsp_ack) begin
                    state   <= state == ST_WAIT_ACK1 ? ST_SEND_ARG : ST_IDLE;
                    retries <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // pass received bytes on, except acknowledge/resend replies the sequencer consumes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_fwd_stb  <= 1'b0;
            rx_fwd_data <= 8'h00;
        end else begin
            rx_fwd_stb <= rx_done_stb && !(rsp_ack || rsp_resend);
            if (rx_done_stb && !(rsp_ack || rsp_resend))
                rx_fwd_data <= rx_data;
        end
    end

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// tb_ps2_led_sequencer: directed scenario tests for the LED command sequencer
module tb_ps2_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_data_stb = 1'b0;
    logic [7:0] key_data = 8'h00;
    logic       key_broken = 1'b0;
    logic       rx_done_stb = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_enable;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done_stb = 1'b0;
    logic       tx_err = 1'b0;
    logic       rx_fwd_stb;
    logic [7:0] rx_fwd_data;
    logic [2:0] lock_state;
    logic       err_stb;

    int checks = 0;
    int errors = 0;
    int tx_starts = 0;
    int err_seen = 0;

    ps2_led_sequencer #(.TIMEOUT_CYC(20), .MAX_RETRY(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_data_stb (key_data_stb),
        .key_data     (key_data),
        .key_broken   (key_broken),
        .rx_done_stb  (rx_done_stb),
        .rx_data      (rx_data),
        .rx_enable    (rx_enable),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done_stb  (tx_done_stb),
        .tx_err       (tx_err),
        .rx_fwd_stb   (rx_fwd_stb),
        .rx_fwd_data  (rx_fwd_data),
        .lock_state   (lock_state),
        .err_stb      (err_stb)
    );

    always #5 clk = ~clk;

    // pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (tx_start) tx_starts <= tx_starts + 1;
        if (err_stb) err_seen <= err_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        key_data_stb = 1'b0;
        rx_done_stb = 1'b0;
        tx_done_stb = 1'b0;
        tx_err = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic press(input logic [7:0] code, input logic brk);
        key_data = code;
        key_broken = brk;
        key_data_stb = 1'b1;
        tick();
        key_data_stb = 1'b0;
    endtask

    task automatic pulse_tx(input logic err);
        tx_done_stb = 1'b1;
        tx_err = err;
        tick();
        tx_done_stb = 1'b0;
        tx_err = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data = b;
        rx_done_stb = 1'b1;
        tick();
        rx_done_stb = 1'b0;
    endtask

    task automatic wait_tx(output logic [7:0] d, output logic ok);
        ok = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx_start) begin
                ok = 1'b1;
                d = tx_data;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({lock_state, tx_start, tx_data, rx_enable, rx_fwd_stb, rx_fwd_data, err_stb} !== {3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: lock=%b tx_start=%b tx_data=%h rx_en=%b fwd=%b/%h err=%b expected 000 0 00 1 0/00 0",
                     lock_state, tx_start, tx_data, rx_enable, rx_fwd_stb, rx_fwd_data, err_stb);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ignore;
        int s0;
        do_reset();
        s0 = tx_starts;
        press(8'h58, 1'b1);
        checks++;
        if (lock_state !== 3'b000) begin errors++; $display("FAIL ignore_break: lock_state=%b expected 000", lock_state); end
        press(8'h1C, 1'b0);
        checks++;
        if (lock_state !== 3'b000) begin errors++; $display("FAIL ignore_other: lock_state=%b expected 000", lock_state); end
        repeat (8) tick();
        checks++;
        if (tx_starts != s0) begin errors++; $display("FAIL ignore_no_tx: tx_start pulses=%0d expected 0", tx_starts - s0); end
    endtask

    task automatic test_caps;
        logic [7:0] d;
        logic ok;
        int s0, e0;
        do_reset();
        s0 = tx_starts;
        e0 = err_seen;
        press(8'h58, 1'b0);
        checks++;
        if (lock_state !== 3'b100) begin errors++; $display("FAIL caps_lock: lock_state=%b expected 100", lock_state); end
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'hED || rx_enable !== 1'b0) begin errors++; $display("FAIL caps_cmd: started=%b tx_data=%h rx_en=%b expected 1 ed 0", ok, d, rx_enable); end
        pulse_tx(1'b0);
        checks++;
        if (rx_enable !== 1'b1) begin errors++; $display("FAIL caps_rx_enable: rx_enable=%b expected 1", rx_enable); end
        pulse_rx(8'hFA);
        checks++;
        if (rx_fwd_stb !== 1'b0) begin errors++; $display("FAIL caps_ack1_fwd: rx_fwd_stb=%b expected 0", rx_fwd_stb); end
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h04) begin errors++; $display("FAIL caps_arg: started=%b tx_data=%h expected 1 04", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        checks++;
        if (rx_fwd_stb !== 1'b0) begin errors++; $display("FAIL caps_ack2_fwd: rx_fwd_stb=%b expected 0", rx_fwd_stb); end
        repeat (8) tick();
        checks++;
        if (tx_starts - s0 != 2 || err_seen != e0) begin errors++; $display("FAIL caps_done: tx pulses=%0d err pulses=%0d expected 2 0", tx_starts - s0, err_seen - e0); end
    endtask

    task automatic test_resend;
        logic [7:0] d;
        logic ok;
        int s0, e0;
        do_reset();
        s0 = tx_starts;
        e0 = err_seen;
        press(8'h77, 1'b0);
        checks++;
        if (lock_state !== 3'b010) begin errors++; $display("FAIL resend_lock: lock_state=%b expected 010", lock_state); end
        wait_tx(d, ok);
        pulse_tx(1'b0);
        pulse_rx(8'hFE);
        checks++;
        if (rx_fwd_stb !== 1'b0) begin errors++; $display("FAIL resend_fe_fwd: rx_fwd_stb=%b expected 0", rx_fwd_stb); end
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'hED) begin errors++; $display("FAIL resend_cmd_again: started=%b tx_data=%h expected 1 ed", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h02) begin errors++; $display("FAIL resend_arg: started=%b tx_data=%h expected 1 02", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        repeat (8) tick();
        checks++;
        if (tx_starts - s0 != 3 || err_seen != e0) begin errors++; $display("FAIL resend_done: tx pulses=%0d err pulses=%0d expected 3 0", tx_starts - s0, err_seen - e0); end
    endtask

    task automatic test_timeout;
        logic [7:0] d;
        logic ok;
        int n, e0;
        do_reset();
        e0 = err_seen;
        press(8'h7E, 1'b0);
        wait_tx(d, ok);
        pulse_tx(1'b0);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            key_data = 8'h58;
            key_broken = 1'b0;
            key_data_stb = (i == 3);
            tick();
            if (err_stb) begin
                n = i;
                break;
            end
        end
        key_data_stb = 1'b0;
        checks++;
        if (n != 20) begin errors++; $display("FAIL timeout_latency: err_stb after %0d cycles expected 20", n); end
        checks++;
        if (lock_state !== 3'b101) begin errors++; $display("FAIL timeout_lock: lock_state=%b expected 101", lock_state); end
        tick();
        checks++;
        if (err_stb !== 1'b0) begin errors++; $display("FAIL timeout_err_width: err_stb=%b expected 0", err_stb); end
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'hED) begin errors++; $display("FAIL timeout_restart: started=%b tx_data=%h expected 1 ed", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h05) begin errors++; $display("FAIL timeout_restart_arg: started=%b tx_data=%h expected 1 05", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        repeat (4) tick();
        checks++;
        if (err_seen - e0 != 1) begin errors++; $display("FAIL timeout_err_count: err pulses=%0d expected 1", err_seen - e0); end
    endtask

    task automatic test_tx_err;
        logic [7:0] d;
        logic ok;
        int s0, e0;
        do_reset();
        s0 = tx_starts;
        e0 = err_seen;
        press(8'h58, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_tx(d, ok);
            checks++;
            if (!ok || d !== 8'hED) begin errors++; $display("FAIL txerr_attempt%0d: started=%b tx_data=%h expected 1 ed", i, ok, d); end
            pulse_tx(1'b1);
        end
        checks++;
        if (err_stb !== 1'b1) begin errors++; $display("FAIL txerr_abort: err_stb=%b expected 1", err_stb); end
        repeat (10) tick();
        checks++;
        if (tx_starts - s0 != 4 || err_seen - e0 != 1) begin errors++; $display("FAIL txerr_counts: tx pulses=%0d err pulses=%0d expected 4 1", tx_starts - s0, err_seen - e0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic ok;
        int s1, e0;
        do_reset();
        e0 = err_seen;
        press(8'h58, 1'b0);
        wait_tx(d, ok);
        pulse_tx(1'b0);
        pulse_rx(8'h1C);
        checks++;
        if (rx_fwd_stb !== 1'b1 || rx_fwd_data !== 8'h1C) begin errors++; $display("FAIL b2b_fwd_in_ack: fwd=%b/%h expected 1/1c", rx_fwd_stb, rx_fwd_data); end
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h04) begin errors++; $display("FAIL b2b_arg1: started=%b tx_data=%h expected 1 04", ok, d); end
        pulse_tx(1'b0);
        press(8'h7E, 1'b0);
        checks++;
        if (lock_state !== 3'b101) begin errors++; $display("FAIL b2b_lock: lock_state=%b expected 101", lock_state); end
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'hED) begin errors++; $display("FAIL b2b_cmd2: started=%b tx_data=%h expected 1 ed", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h05) begin errors++; $display("FAIL b2b_arg2: started=%b tx_data=%h expected 1 05", ok, d); end
        pulse_tx(1'b0);
        key_data = 8'h77;
        key_broken = 1'b0;
        key_data_stb = 1'b1;
        rx_data = 8'hFA;
        rx_done_stb = 1'b1;
        tick();
        key_data_stb = 1'b0;
        rx_done_stb = 1'b0;
        checks++;
        if (lock_state !== 3'b111) begin errors++; $display("FAIL b2b_sim_lock: lock_state=%b expected 111", lock_state); end
        wait_tx(d, ok);
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h07) begin errors++; $display("FAIL b2b_sim_arg: started=%b tx_data=%h expected 1 07", ok, d); end
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        tick();
        s1 = tx_starts;
        repeat (10) tick();
        checks++;
        if (tx_starts != s1 || err_seen != e0) begin errors++; $display("FAIL b2b_single: extra tx pulses=%0d err pulses=%0d expected 0 0", tx_starts - s1, err_seen - e0); end
        pulse_rx(8'h1C);
        checks++;
        if (rx_fwd_stb !== 1'b1 || rx_fwd_data !== 8'h1C) begin errors++; $display("FAIL b2b_fwd_idle: fwd=%b/%h expected 1/1c", rx_fwd_stb, rx_fwd_data); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic ok;
        int s1, e0;
        do_reset();
        e0 = err_seen;
        press(8'h58, 1'b0);
        wait_tx(d, ok);
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        wait_tx(d, ok);
        checks++;
        if (!ok || d !== 8'h04) begin errors++; $display("FAIL rstmid_arg: started=%b tx_data=%h expected 1 04", ok, d); end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({lock_state, tx_start, tx_data, rx_enable, rx_fwd_stb, rx_fwd_data, err_stb} !== {3'b000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: lock=%b tx_start=%b tx_data=%h rx_en=%b fwd=%b/%h err=%b expected 000 0 00 1 0/00 0",
                     lock_state, tx_start, tx_data, rx_enable, rx_fwd_stb, rx_fwd_data, err_stb);
        end
        tick();
        rst_n = 1'b1;
        tick();
        s1 = tx_starts;
        pulse_tx(1'b0);
        pulse_rx(8'hFA);
        checks++;
        if (rx_fwd_stb !== 1'b1 || rx_fwd_data !== 8'hFA) begin errors++; $display("FAIL rstmid_idle_fwd: fwd=%b/%h expected 1/fa", rx_fwd_stb, rx_fwd_data); end
        repeat (6) tick();
        checks++;
        if (tx_starts != s1 || err_seen != e0 || rx_enable !== 1'b1) begin errors++; $display("FAIL rstmid_quiet: tx pulses=%0d err pulses=%0d rx_en=%b expected 0 0 1", tx_starts - s1, err_seen - e0, rx_enable); end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_caps();
        test_resend();
        test_timeout();
        test_tx_err();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_led_sequencer.md
PS2_LED_SEQUENCER -- requirements
Module: ps2_led_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1_000_000: clk cycles to wait for a keyboard response byte (20 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 3: resend attempts per command byte before abort.
REQ-003 clk  in  1  system clock; all logic on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 key_data_stb  in  1  one-cycle strobe: key_data/key_broken valid.
REQ-006 key_data  in  8  decoded key code; key_broken  in  1  1 = break event.
REQ-007 rx_done_stb  in  1 and rx_data  in  8: raw byte received from the PS/2 listener.
REQ-008 rx_enable  out  1  listener enable.
REQ-009 tx_start  out  1 and tx_data  out  8: one-cycle request to the PS/2 transmitter.
REQ-010 tx_done_stb  in  1  transmit complete; tx_err  in  1  valid with tx_done_stb, 1 = no device ACK bit.
REQ-011 rx_fwd_stb  out  1 and rx_fwd_data  out  8: bytes passed on to the scancode converter.
REQ-012 lock_state  out  3  {caps, num, scroll}; err_stb  out  1  one-cycle abort indication.

Function
REQ-013 Lock keys: make events (key_broken=0) with key_data 0x58/0x77/0x7E SHALL toggle lock_state[2]/[1]/[0] on the cycle after key_data_stb; break events and all other codes SHALL be ignored.
REQ-014 Any toggle SHALL set the pending flag; pending SHALL clear when IDLE launches a sequence.
REQ-015 States: IDLE, SEND_CMD, WAIT_TX1, WAIT_ACK1, SEND_ARG, WAIT_TX2, WAIT_ACK2.
REQ-016 IDLE with pending=1 -> SEND_CMD; the argument byte {5'b0, caps, num, scroll} SHALL be latched at this transition.
REQ-017 SEND_CMD SHALL pulse tx_start for one cycle with tx_data=0xED -> WAIT_TX1; SEND_ARG SHALL pulse tx_start with the latched argument -> WAIT_TX2.
REQ-018 WAIT_TXn: tx_done_stb with tx_err=0 -> WAIT_ACKn; tx_done_stb with tx_err=1 counts as a retry and returns to the corresponding SEND state.
REQ-019 WAIT_ACKn: rx byte 0xFA -> SEND_ARG (n=1) or IDLE (n=2); byte 0xFE counts as a retry and returns to the same SEND state.
REQ-020 Retry count SHALL reset to 0 on each byte's first transmission; when a retry would exceed MAX_RETRY, or the response timer reaches TIMEOUT_CYC, the FSM SHALL go to IDLE and pulse err_stb.
REQ-021 The response timer SHALL clear on entry to WAIT_ACKn and count every cycle in that state.
REQ-022 tx_data SHALL hold its value from tx_start until leaving WAIT_TXn.
REQ-023 rx_enable SHALL be 0 from the tx_start cycle until the cycle after tx_done_stb, and 1 at all other times.
REQ-024 Forwarding: rx bytes SHALL appear on rx_fwd_stb/rx_fwd_data one cycle after rx_done_stb, except 0xFA/0xFE received in WAIT_ACKn, which are consumed; other bytes in WAIT_ACKn are forwarded and do not change state.
REQ-025 A toggle during an active sequence SHALL update lock_state immediately and set pending; IDLE SHALL start a new sequence the cycle after returning, including after an abort.
REQ-026 A simultaneous key_data_stb and FSM return to IDLE SHALL produce exactly one further sequence carrying the new state.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, lock_state=3'b000, pending=0, retries=0, timer=0, tx_start=0, tx_data=0x00, rx_enable=1, rx_fwd_stb=0, rx_fwd_data=0x00, err_stb=0.
REQ-028 Reset mid-sequence SHALL abandon it with no err_stb; a tx_done_stb arriving after reset release in IDLE SHALL be ignored.

Structure
REQ-029 A shared ps2 package SHALL hold the state encoding, 0xED/0xFA/0xFE command constants and lock-key code constants 0x58/0x77/0x7E.
REQ-030 The response timer SHALL be one sub-module, ps2_timeout_counter (clear, enable, expired output).

Verification
REQ-031 Caps make (0x58) -> lock_state=100; tx 0xED, reply 0xFA, tx 0x04, reply 0xFA -> IDLE; neither 0xFA forwarded.
REQ-032 Num make, first reply 0xFE -> 0xED resent once; then 0xFA, arg 0x02, 0xFA -> done, err_stb never pulses.
REQ-033 No reply after 0xED -> err_stb exactly TIMEOUT_CYC cycles after WAIT_ACK1 entry; pending toggle then restarts.
REQ-034 Four consecutive tx_err=1 on 0xED with MAX_RETRY=3 -> exactly 4 tx_start pulses, then err_stb, IDLE.
REQ-035 Scroll make during WAIT_ACK2 of a caps sequence -> second sequence with arg 0x05; scancode 0x1C in IDLE forwarded one cycle later.
REQ-036 rst_n low during WAIT_TX2 -> all outputs at reset values asynchronously; rx_enable=1.
